sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_PERIOD, default 390, gives the clocks between refresh requests.
REQ-002 Parameter SLOT_LEN, default 12, gives the clocks from strobe assertion to slot completion.
REQ-003 Parameter STROBE_LEN, default 2, gives the clocks a strobe is held low.
REQ-004 Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ready  in  1  controller initialised.
- cpuRd, cpuWr  in  1 each  CPU level requests.
- cpuA  in  24  CPU byte address.
- cpuD  in  8  CPU write data.
- cpuQ  out  8  CPU read data.
- cpuAck  out  1  one-clock completion pulse.
- vidRd  in  1  video level read request.
- vidA  in  24  video word address.
- vidQ  out  16  video read data.
- vidAck  out  1  one-clock completion pulse.
- memRead, memWrite, memRefresh  out  1 each  active-low strobes; idle high; controller acts on falling edge.
- memA  out  24  word address.
- memD  out  16  write data.
- memQ  in  16  controller read data.

Function
REQ-005 States: sIDLE, sREFRESH, sVREAD, sCREAD, sCWRITE, sRMWREAD, sRMWWRITE; each non-idle state is one slot of SLOT_LEN clocks.
REQ-006 At slot entry the arbiter SHALL pull exactly one strobe low for STROBE_LEN clocks, then hold it high for the rest of the slot.
REQ-007 memA and memD SHALL be stable from slot entry to slot end.
REQ-008 The refresh counter SHALL run continuously from 0 to REFRESH_PERIOD-1, setting refPending on wrap.
REQ-009 A further wrap while refPending is already set SHALL leave it set, with no count accumulated.
REQ-010 In sIDLE with ready high, the arbiter SHALL grant by priority: refPending, then armed vidRd, then armed cpuWr, then armed cpuRd.
REQ-011 When cpuRd and cpuWr are both high, the write SHALL win and the read SHALL be ignored for that transaction.
REQ-012 With ready low, no strobe SHALL be issued; requests stay pending and the refresh counter keeps running.
REQ-013 A port SHALL be armed after reset, disarmed on grant, and re-armed only once its request is sampled low, so a held request never issues twice.
REQ-014 Read slots SHALL capture memQ in the final slot clock (SLOT_LEN-1) into vidQ or cpuQ, then pulse the ack for one clock.
REQ-015 Ack SHALL coincide with the return to sIDLE, and a new grant SHALL occur no earlier than the following clock.
REQ-016 sREFRESH SHALL clear refPending at slot entry and produce no ack.
REQ-017 vidQ and cpuQ SHALL hold their values between reads.

Reset
REQ-018 reset SHALL force sIDLE, all strobes high, cpuAck=vidAck=0, refPending=0, refresh counter=0, slot counter=0 and all ports armed.
REQ-019 reset SHALL force cpuQ, vidQ, memA and memD to 0.
REQ-020 An in-flight slot SHALL be abandoned on reset without an ack.

Configuration
REQ-021 With SDRAM_RMW_EN defined, the CPU byte at cpuA SHALL map to word cpuA[23:1], with cpuA[0]=1 selecting the high byte.
REQ-022 With SDRAM_RMW_EN, cpuRd SHALL return the selected byte of memQ.
REQ-023 With SDRAM_RMW_EN, cpuWr SHALL run sRMWREAD then sRMWWRITE, writing the merged word and acking once after the write slot; refresh cannot intervene between the two.
REQ-024 Without SDRAM_RMW_EN, memA SHALL be cpuA; writes use sCWRITE with memD={8'h00,cpuD}, and reads return memQ[7:0].

Structure
REQ-025 A shared package SHALL hold the state encoding and the default values of REFRESH_PERIOD, SLOT_LEN and STROBE_LEN.
REQ-026 The refresh timer SHALL be a sub-module named sdram_refresh_timer, with ports clock, reset and pending-clear in, and pending out.

Verification
REQ-027 After reset with ready=1 and no requests, memRefresh SHALL fall at clock 390 and again at 780, with no other strobe.
REQ-028 vidRd=1 with vidA=24'h000100 and memQ=16'hBEEF SHALL produce one memRead low for 2 clocks, vidQ=16'hBEEF and vidAck 12 clocks after the fall, and no reissue while vidRd stays high.
REQ-029 cpuWr and vidRd raised in the same clock SHALL complete the video slot first, then the CPU slot, with one ack each.
REQ-030 With SDRAM_RMW_EN, cpuWr with cpuA=24'h000003, cpuD=8'h5A and memQ=16'h1234 SHALL produce memRead, then memWrite with memA=24'h000001 and memD=16'h5A34, then a single cpuAck.
REQ-031 With ready=0, a pending cpuRd SHALL issue no strobe; after ready rises, memRead SHALL fall within 1 clock.
REQ-032 reset asserted at clock 5 of a CPU read slot SHALL raise all strobes and give no cpuAck; re-raising cpuRd after reset SHALL complete normally.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
// Shared definitions for the SDRAM arbiter: the slot state encoding, the
// default timing parameters and the byte-merge helper used by the optional
// read-modify-write path (SDRAM_RMW_EN).
// No ports; imported by sdram_arbiter and sdram_refresh_timer.

package sdram_arbiter_pkg;

   // One idle state plus one state per kind of memory slot.
   typedef enum logic [2:0] {
      sIDLE     = 3'd0,
      sREFRESH  = 3'd1,
      sVREAD    = 3'd2,
      sCREAD    = 3'd3,
      sCWRITE   = 3'd4,
      sRMWREAD  = 3'd5,
      sRMWWRITE = 3'd6
   } state_e;

   localparam int REFRESH_PERIOD_DEF = 390;
   localparam int SLOT_LEN_DEF       = 12;
   localparam int STROBE_LEN_DEF     = 2;

   // Replace the selected byte of a 16-bit word with new data; hi selects
   // the upper byte.
   function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                              input logic [7:0]  data,
                                              input logic        hi);
      merge_byte = hi ? {data, word[7:0]} : {word[15:8], data};
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer
// Free-running refresh interval counter. Counts 0..REFRESH_PERIOD-1 forever
// and raises a sticky pending flag each time it wraps. Wraps that land while
// the flag is already set are simply absorbed, so refresh debt never piles up.
// Ports:
//   clock          in   sole clock, posedge
//   reset          in   synchronous, active-high
//   pending_clear  in   arbiter has started a refresh slot
//   pending        out  a refresh is owed

module sdram_refresh_timer
   import sdram_arbiter_pkg::*;
#(
   parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic pending_clear,
   output logic pending
);

   localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

   logic [CW-1:0] count_q, count_d;
   logic          pending_q, pending_d;
   logic          wrap;

   // Next-count and pending logic. A wrap wins over a clear in the same clock
   // so a request raised exactly as the previous one is serviced is not lost.
   always_comb begin
      wrap      = (count_q == CW'(REFRESH_PERIOD - 1));
      count_d   = wrap ? '0 : count_q + CW'(1);
      pending_d = pending_q;
      if (wrap) begin
         pending_d = 1'b1;
      end else if (pending_clear) begin
         pending_d = 1'b0;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Time-slot arbiter between a CPU byte port, a video word-read port and
// periodic refresh, in front of a strobe-driven SDRAM controller. Each grant
// opens a slot of SLOT_LEN clocks in which exactly one active-low strobe is
// held low for STROBE_LEN clocks; address and write data stay put for the
// whole slot. Read data is captured in the last slot clock and the requesting
// port gets a one-clock ack as the arbiter returns to idle.
// Optional feature macro: SDRAM_RMW_EN -- CPU bytes map onto 16-bit words
// (cpuA[0] picks the byte), CPU writes become read-modify-write pairs.
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   ready                             controller initialised, gates all grants
//   cpuRd, cpuWr, cpuA, cpuD          CPU level requests, byte address, data
//   cpuQ, cpuAck                      CPU read data and completion pulse
//   vidRd, vidA                       video level read request, word address
//   vidQ, vidAck                      video read data and completion pulse
//   memRead, memWrite, memRefresh     active-low controller strobes
//   memA, memD, memQ                  word address, write data, read data

module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
   parameter int SLOT_LEN       = SLOT_LEN_DEF,
   parameter int STROBE_LEN     = STROBE_LEN_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ready,
   input  logic        cpuRd,
   input  logic        cpuWr,
   input  logic [23:0] cpuA,
   input  logic [7:0]  cpuD,
   output logic [7:0]  cpuQ,
   output logic        cpuAck,
   input  logic        vidRd,
   input  logic [23:0] vidA,
   output logic [15:0] vidQ,
   output logic        vidAck,
   output logic        memRead,
   output logic        memWrite,
   output logic        memRefresh,
   output logic [23:0] memA,
   output logic [15:0] memD,
   input  logic [15:0] memQ
);

   localparam int SCW = $clog2(SLOT_LEN + 1);

   state_e          state_q, state_d;
   logic [SCW-1:0]  slot_cnt_q, slot_cnt_d, slot_cnt_nx;
   logic            slot_last;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            mem_refresh_q, mem_refresh_d;
   logic [23:0]     mem_a_q, mem_a_d;
   logic [15:0]     mem_d_q, mem_d_d;
   logic [7:0]      cpu_data_q, cpu_data_d;
   logic [15:0]     vid_data_q, vid_data_d;
   logic            cpu_ack_q, cpu_ack_d;
   logic            vid_ack_q, vid_ack_d;
   logic            vid_armed_q, vid_armed_d;
   logic            cpu_armed_q, cpu_armed_d;
   logic            ref_pending;
   logic            ref_clear;
`ifdef SDRAM_RMW_EN
   logic [7:0]      wr_byte_q, wr_byte_d;
   logic            hi_sel_q, hi_sel_d;
`endif

   sdram_refresh_timer #(
      .REFRESH_PERIOD(REFRESH_PERIOD)
   ) u_refresh_timer (
      .clock         (clock),
      .reset         (reset),
      .pending_clear (ref_clear),
      .pending       (ref_pending)
   );

   // Next-state logic for the slot machine. In idle we grant by priority;
   // inside a slot we count clocks, release the strobe after STROBE_LEN and
   // finish on the last clock. The CPU port is one arming unit: a write that
   // wins over a simultaneous read consumes the whole port, so the read is
   // dropped until both requests have been seen low.
   always_comb begin
      state_d       = state_q;
      slot_cnt_d    = slot_cnt_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_refresh_d = mem_refresh_q;
      mem_a_d       = mem_a_q;
      mem_d_d       = mem_d_q;
      cpu_data_d    = cpu_data_q;
      vid_data_d    = vid_data_q;
      cpu_ack_d     = 1'b0;
      vid_ack_d     = 1'b0;
      ref_clear     = 1'b0;
      vid_armed_d   = vid_armed_q | ~vidRd;
      cpu_armed_d   = cpu_armed_q | ~(cpuRd | cpuWr);
      slot_cnt_nx   = slot_cnt_q + SCW'(1);
      slot_last     = (slot_cnt_q == SCW'(SLOT_LEN - 1));
`ifdef SDRAM_RMW_EN
      wr_byte_d     = wr_byte_q;
      hi_sel_d      = hi_sel_q;
`endif

      if (state_q == sIDLE) begin
         slot_cnt_d = '0;
         if (ready) begin
            if (ref_pending) begin
               state_d       = sREFRESH;
               mem_refresh_d = 1'b0;
               ref_clear     = 1'b1;
            end else if (vid_armed_q && vidRd) begin
               state_d     = sVREAD;
               mem_read_d  = 1'b0;
               mem_a_d     = vidA;
               vid_armed_d = 1'b0;
            end else if (cpu_armed_q && cpuWr) begin
               cpu_armed_d = 1'b0;
`ifdef SDRAM_RMW_EN
               state_d     = sRMWREAD;
               mem_read_d  = 1'b0;
               mem_a_d     = {1'b0, cpuA[23:1]};
               wr_byte_d   = cpuD;
               hi_sel_d    = cpuA[0];
`else
               state_d     = sCWRITE;
               mem_write_d = 1'b0;
               mem_a_d     = cpuA;
               mem_d_d     = {8'h00, cpuD};
`endif
            end else if (cpu_armed_q && cpuRd) begin
               cpu_armed_d = 1'b0;
               state_d     = sCREAD;
               mem_read_d  = 1'b0;
`ifdef SDRAM_RMW_EN
               mem_a_d     = {1'b0, cpuA[23:1]};
               hi_sel_d    = cpuA[0];
`else
               mem_a_d     = cpuA;
`endif
            end
         end
      end else begin
         slot_cnt_d = slot_cnt_nx;
         if (slot_cnt_nx >= SCW'(STROBE_LEN)) begin
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b1;
            mem_refresh_d = 1'b1;
         end
         if (slot_last) begin
            slot_cnt_d = '0;
            state_d    = sIDLE;
            case (state_q)
               sVREAD: begin
                  vid_data_d = memQ;
                  vid_ack_d  = 1'b1;
               end
               sCREAD: begin
`ifdef SDRAM_RMW_EN
                  cpu_data_d = hi_sel_q ? memQ[15:8] : memQ[7:0];
`else
                  cpu_data_d = memQ[7:0];
`endif
                  cpu_ack_d  = 1'b1;
               end
               sCWRITE: cpu_ack_d = 1'b1;
`ifdef SDRAM_RMW_EN
               // Chain straight into the write half so nothing, not even
               // refresh, can touch the word between read and write.
               sRMWREAD: begin
                  state_d     = sRMWWRITE;
                  mem_write_d = 1'b0;
                  mem_d_d     = merge_byte(memQ, wr_byte_q, hi_sel_q);
               end
               sRMWWRITE: cpu_ack_d = 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   // All arbiter state and registered outputs. Reset abandons any slot in
   // flight without acking it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= sIDLE;
         slot_cnt_q    <= '0;
         mem_read_q    <= 1'b1;
         mem_write_q   <= 1'b1;
         mem_refresh_q <= 1'b1;
         mem_a_q       <= '0;
         mem_d_q       <= '0;
         cpu_data_q    <= '0;
         vid_data_q    <= '0;
         cpu_ack_q     <= 1'b0;
         vid_ack_q     <= 1'b0;
         vid_armed_q   <= 1'b1;
         cpu_armed_q   <= 1'b1;
`ifdef SDRAM_RMW_EN
         wr_byte_q     <= '0;
         hi_sel_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         slot_cnt_q    <= slot_cnt_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_refresh_q <= mem_refresh_d;
         mem_a_q       <= mem_a_d;
         mem_d_q       <= mem_d_d;
         cpu_data_q    <= cpu_data_d;
         vid_data_q    <= vid_data_d;
         cpu_ack_q     <= cpu_ack_d;
         vid_ack_q     <= vid_ack_d;
         vid_armed_q   <= vid_armed_d;
         cpu_armed_q   <= cpu_armed_d;
`ifdef SDRAM_RMW_EN
         wr_byte_q     <= wr_byte_d;
         hi_sel_q      <= hi_sel_d;
`endif
      end
   end

   assign memRead    = mem_read_q;
   assign memWrite   = mem_write_q;
   assign memRefresh = mem_refresh_q;
   assign memA       = mem_a_q;
   assign memD       = mem_d_q;
   assign cpuQ       = cpu_data_q;
   assign cpuAck     = cpu_ack_q;
   assign vidQ       = vid_data_q;
   assign vidAck     = vid_ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed scenarios followed by random traffic on sdram_arbiter, checked
// every clock against a transaction-level model that tracks which slot is
// open and when it started, and derives strobes, acks and data from that.

module tb_sdram_arbiter;

   localparam int PERIOD = 390;
   localparam int SLOT   = 12;
   localparam int STROBE = 2;

   localparam int OP_NONE = 0, OP_REF = 1, OP_VID = 2, OP_CRD = 3,
                  OP_CWR = 4, OP_RMWR = 5, OP_RMWW = 6;

   logic        clock = 1'b0;
   logic        reset, ready, cpuRd, cpuWr, vidRd;
   logic [23:0] cpuA, vidA;
   logic [7:0]  cpuD, cpuQ;
   logic        cpuAck, vidAck;
   logic [15:0] vidQ, memD, memQ;
   logic        memRead, memWrite, memRefresh;
   logic [23:0] memA;

   sdram_arbiter dut (
      .clock(clock), .reset(reset), .ready(ready),
      .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD),
      .cpuQ(cpuQ), .cpuAck(cpuAck),
      .vidRd(vidRd), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
      .memRead(memRead), .memWrite(memWrite), .memRefresh(memRefresh),
      .memA(memA), .memD(memD), .memQ(memQ)
   );

   always #5 clock = ~clock;

   int testsRun = 0;
   int testsFailed = 0;

   // Model state: the open operation, the clock its current phase began,
   // refresh age since reset and the per-port arming flags.
   int          op = OP_NONE;
   int          phaseStart = 0;
   int          edgeN = 0;
   int          curEdge = 0;
   int          age = 0;
   int          curAge = 0;
   bit          pend = 0, vArm = 1, cArm = 1, hiSel = 0;
   logic [7:0]  wrByte = 0;
   logic [23:0] eA = 0;
   logic [15:0] eD = 0, eVQ = 0;
   logic [7:0]  eCQ = 0;
   bit          eVAck = 0, eCAck = 0, eRd = 1, eWr = 1, eRf = 1;

   // Observed-event bookkeeping for the directed scenarios.
   int          rdFalls, wrFalls, rfFalls, vAcks, cAcks;
   int          lastRdFall, lastVAck, lastCAck;
   int          rfFallAge[$];
   logic [23:0] wrFallA;
   logic [15:0] wrFallD;
   logic        prevRd = 1'b1, prevWr = 1'b1, prevRf = 1'b1;
   logic        rv, rc, rw, rr, rs;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy, input logic vr,
                                input logic cr, input logic cw);
      reset = rst;
      ready = rdy;
      vidRd = vr;
      cpuRd = cr;
      cpuWr = cw;
   endtask

   task automatic clearCounters();
      rdFalls = 0; wrFalls = 0; rfFalls = 0; vAcks = 0; cAcks = 0;
      lastRdFall = -1; lastVAck = -1; lastCAck = -1;
      rfFallAge.delete();
      wrFallA = 'x; wrFallD = 'x;
   endtask

   // Predict the outputs after the coming clock edge from the inputs now
   // applied.
   task automatic modelStep();
      bit gV, gC, clr, low;
      gV = 0; gC = 0; clr = 0;
      curEdge = edgeN;
      curAge  = age;
      eVAck = 0; eCAck = 0;
      if (reset) begin
         op = OP_NONE; pend = 0; age = 0; vArm = 1; cArm = 1;
         eA = 0; eD = 0; eVQ = 0; eCQ = 0;
      end else begin
         if (op != OP_NONE) begin
            if (curEdge - phaseStart == SLOT) begin
               case (op)
                  OP_VID: begin eVQ = memQ; eVAck = 1; op = OP_NONE; end
                  OP_CRD: begin
`ifdef SDRAM_RMW_EN
                     eCQ = hiSel ? memQ[15:8] : memQ[7:0];
`else
                     eCQ = memQ[7:0];
`endif
                     eCAck = 1; op = OP_NONE;
                  end
                  OP_RMWR: begin
                     eD = hiSel ? {wrByte, memQ[7:0]} : {memQ[15:8], wrByte};
                     op = OP_RMWW; phaseStart = curEdge;
                  end
                  OP_CWR, OP_RMWW: begin eCAck = 1; op = OP_NONE; end
                  default: op = OP_NONE;
               endcase
            end
         end else if (ready) begin
            if (pend) begin
               op = OP_REF; clr = 1; phaseStart = curEdge;
            end else if (vArm && vidRd) begin
               op = OP_VID; eA = vidA; gV = 1; phaseStart = curEdge;
            end else if (cArm && (cpuWr || cpuRd)) begin
               gC = 1; phaseStart = curEdge;
`ifdef SDRAM_RMW_EN
               eA = cpuA >> 1; hiSel = cpuA[0];
               if (cpuWr) begin op = OP_RMWR; wrByte = cpuD; end
               else op = OP_CRD;
`else
               eA = cpuA;
               if (cpuWr) begin op = OP_CWR; eD = {8'h00, cpuD}; end
               else op = OP_CRD;
`endif
            end
         end
         if (age % PERIOD == PERIOD - 1) pend = 1;
         else if (clr) pend = 0;
         vArm = gV ? 1'b0 : (vArm | ~vidRd);
         cArm = gC ? 1'b0 : (cArm | ~(cpuRd | cpuWr));
         age++;
      end
      low = (op != OP_NONE) && (curEdge - phaseStart < STROBE);
      eRd = !(low && (op == OP_VID || op == OP_CRD || op == OP_RMWR));
      eWr = !(low && (op == OP_CWR || op == OP_RMWW));
      eRf = !(low && op == OP_REF);
      edgeN++;
   endtask

   task automatic runCycle();
      modelStep();
      @(posedge clock);
      #1;
      checkOutput("memRead", memRead, eRd);
      checkOutput("memWrite", memWrite, eWr);
      checkOutput("memRefresh", memRefresh, eRf);
      checkOutput("memA", memA, eA);
      checkOutput("memD", memD, eD);
      checkOutput("cpuQ", cpuQ, eCQ);
      checkOutput("vidQ", vidQ, eVQ);
      checkOutput("cpuAck", cpuAck, eCAck);
      checkOutput("vidAck", vidAck, eVAck);
      if (prevRd === 1'b1 && memRead === 1'b0) begin
         rdFalls++; lastRdFall = curEdge;
      end
      if (prevWr === 1'b1 && memWrite === 1'b0) begin
         wrFalls++; wrFallA = memA; wrFallD = memD;
      end
      if (prevRf === 1'b1 && memRefresh === 1'b0) begin
         rfFalls++; rfFallAge.push_back(curAge);
      end
      if (vidAck === 1'b1) begin vAcks++; lastVAck = curEdge; end
      if (cpuAck === 1'b1) begin cAcks++; lastCAck = curEdge; end
      prevRd = memRead; prevWr = memWrite; prevRf = memRefresh;
   endtask

   initial begin
      cpuA = 0; cpuD = 0; vidA = 0; memQ = 0;
      applyStimulus(1, 1, 0, 0, 0);
      clearCounters();

      // Idle with ready: only refresh strobes, at ages 390 and 780.
      repeat (3) runCycle();
      applyStimulus(0, 1, 0, 0, 0);
      clearCounters();
      repeat (800) runCycle();
      checkOutput("ref_count", rfFalls, 2);
      checkOutput("ref_fall1", (rfFallAge.size() > 0) ? rfFallAge[0] : -1, 390);
      checkOutput("ref_fall2", (rfFallAge.size() > 1) ? rfFallAge[1] : -1, 780);
      checkOutput("idle_rw", rdFalls + wrFalls, 0);

      // Held video read: one slot, data and ack 12 clocks after the fall.
      clearCounters();
      vidA = 24'h000100; memQ = 16'hBEEF;
      applyStimulus(0, 1, 1, 0, 0);
      repeat (60) runCycle();
      checkOutput("vid_rd_falls", rdFalls, 1);
      checkOutput("vid_acks", vAcks, 1);
      checkOutput("vid_q", vidQ, 16'hBEEF);
      checkOutput("vid_ack_lat", lastVAck - lastRdFall, SLOT);

      // Video and CPU write raised together: video first, one ack each.
      applyStimulus(0, 1, 0, 0, 0);
      repeat (2) runCycle();
      clearCounters();
      cpuA = 24'h000042; cpuD = 8'hA5;
      applyStimulus(0, 1, 1, 0, 1);
      repeat (50) runCycle();
      checkOutput("both_vacks", vAcks, 1);
      checkOutput("both_cacks", cAcks, 1);
      checkOutput("vid_first", (lastVAck >= 0 && lastVAck < lastCAck), 1);

      // ready low holds a CPU read off; it starts on the edge ready rises.
      applyStimulus(0, 1, 0, 0, 0);
      repeat (2) runCycle();
      clearCounters();
      cpuA = 24'h000010; memQ = 16'h7E81;
      applyStimulus(0, 0, 0, 1, 0);
      repeat (20) runCycle();
      checkOutput("notready_strobes", rdFalls + wrFalls + rfFalls, 0);
      applyStimulus(0, 1, 0, 1, 0);
      runCycle();
      checkOutput("ready_rd", memRead, 0);

      // Reset on clock 5 of that read slot: strobes high, no ack.
      repeat (4) runCycle();
      clearCounters();
      applyStimulus(1, 1, 0, 0, 0);
      runCycle();
      checkOutput("rst_strobes", {memRead, memWrite, memRefresh}, 3'b111);
      applyStimulus(0, 1, 0, 0, 0);
      repeat (15) runCycle();
      checkOutput("rst_no_ack", cAcks, 0);
      applyStimulus(0, 1, 0, 1, 0);
      repeat (20) runCycle();
      checkOutput("rerd_acks", cAcks, 1);

`ifdef SDRAM_RMW_EN
      // Byte write into the high half of word 1.
      applyStimulus(0, 1, 0, 0, 0);
      repeat (2) runCycle();
      clearCounters();
      cpuA = 24'h000003; cpuD = 8'h5A; memQ = 16'h1234;
      applyStimulus(0, 1, 0, 0, 1);
      repeat (30) runCycle();
      checkOutput("rmw_rd", rdFalls, 1);
      checkOutput("rmw_wr", wrFalls, 1);
      checkOutput("rmw_a", wrFallA, 24'h000001);
      checkOutput("rmw_d", wrFallD, 16'h5A34);
      checkOutput("rmw_ack", cAcks, 1);
`endif

      // Random traffic against the model.
      rv = 0; rc = 0; rw = 0;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 15))
            0: rv = ~rv;
            1: rc = ~rc;
            2: rw = ~rw;
            default: ;
         endcase
         rr = ($urandom_range(0, 31) != 0);
         rs = ($urandom_range(0, 999) == 0);
         cpuA = 24'($urandom);
         vidA = 24'($urandom);
         cpuD = 8'($urandom);
         memQ = 16'($urandom);
         applyStimulus(rs, rr, rv, rc, rw);
         runCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
